// File: rtl/sram_burst_ctrl.sv
// Asynchronous SRAM access controller: single and burst reads/writes behind a
// valid/ready command port, with programmable strobe width and bus turnaround.
module sram_burst_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned ACCESS_CYC = 7,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // command port
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  // data port
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  // SRAM side
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_dq_out,
  output logic              o_mem_dq_oe,
  input  logic [DATA_W-1:0] i_mem_dq_in,
  output logic              o_mem_ce_n,
  output logic              o_mem_we_n,
  output logic              o_mem_oe_n,
  output logic              o_mem_lb_n,
  output logic              o_mem_ub_n,
  output logic              o_mem_adv_n,
  output logic              o_mem_cre
);

  localparam int unsigned CNT_MAX = (ACCESS_CYC > TURN_CYC) ? ACCESS_CYC : TURN_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACC_LOAD  = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam bit HAS_TURN = (TURN_CYC != 0);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StRecover
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [LEN_W-1:0]    r_beats, w_beats_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_write, w_write_nxt;
  logic [DATA_W-1:0]   r_dq_out, w_dq_out_nxt;
  logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
  logic                r_rd_valid, w_rd_valid_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_beats    <= '0;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_dq_out   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_beats    <= w_beats_nxt;
      r_cnt      <= w_cnt_nxt;
      r_write    <= w_write_nxt;
      r_dq_out   <= w_dq_out_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  // Beat sequencing: read beats end in ACCESS, write beats end in HOLD.
  always_comb begin
    logic w_beat_done;
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_beats_nxt    = r_beats;
    w_cnt_nxt      = r_cnt;
    w_write_nxt    = r_write;
    w_dq_out_nxt   = r_dq_out;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_beat_done    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_addr_nxt  = i_cmd_addr;
          w_write_nxt = i_cmd_write;
          w_beats_nxt = i_cmd_len;
          w_state_nxt = StSetup;
        end
      end
      StSetup: begin
        if (r_write) begin
          w_dq_out_nxt = i_wr_data;
        end
        w_cnt_nxt   = ACC_LOAD;
        w_state_nxt = StAccess;
      end
      StAccess: begin
        if (r_cnt == '0) begin
          if (r_write) begin
            w_state_nxt = StHold;
          end else begin
            w_rd_data_nxt  = i_mem_dq_in;
            w_rd_valid_nxt = 1'b1;
            w_beat_done    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      StHold: begin
        w_beat_done = 1'b1;
      end
      StRecover: begin
        if (r_cnt == '0) begin
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (w_beat_done) begin
      if (r_beats != '0) begin
        w_beats_nxt = r_beats - LEN_W'(1);
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_state_nxt = StSetup;
      end else if (HAS_TURN) begin
        w_cnt_nxt   = TURN_LOAD;
        w_state_nxt = StRecover;
      end else begin
        w_state_nxt = StIdle;
      end
    end
  end

  // Strobes decode straight from the state register so a reset edge releases them at once.
  always_comb begin
    o_mem_ce_n  = 1'b1;
    o_mem_we_n  = 1'b1;
    o_mem_oe_n  = 1'b1;
    o_mem_dq_oe = 1'b0;
    o_wr_ready  = 1'b0;
    unique case (r_state)
      StSetup: begin
        o_mem_ce_n = 1'b0;
        o_mem_oe_n = r_write;
        o_wr_ready = r_write;
      end
      StAccess: begin
        o_mem_ce_n  = 1'b0;
        o_mem_we_n  = !r_write;
        o_mem_oe_n  = r_write;
        o_mem_dq_oe = r_write;
      end
      StHold: begin
        o_mem_ce_n  = 1'b0;
        o_mem_dq_oe = r_write;
      end
      default: begin
        o_mem_ce_n = 1'b1;
      end
    endcase
  end

  assign o_cmd_ready  = (r_state == StIdle) && !i_rst;
  assign o_busy       = (r_state != StIdle);
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_mem_addr   = r_addr;
  assign o_mem_dq_out = r_dq_out;
  assign o_mem_lb_n   = o_mem_ce_n;
  assign o_mem_ub_n   = o_mem_ce_n;
  assign o_mem_adv_n  = 1'b0;
  assign o_mem_cre    = 1'b0;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: SRAM behavioural model, read-data scoreboard and
// cycle-accurate checks of strobe timing, burst addressing and reset abort.
module tb_sram_burst_ctrl;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned A      = 3;
  localparam int unsigned T      = 2;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic              i_cmd_write;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [LEN_W-1:0]  i_cmd_len;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_wr_ready;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  logic              o_busy;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_dq_out;
  logic              o_mem_dq_oe;
  logic [DATA_W-1:0] i_mem_dq_in;
  logic              o_mem_ce_n, o_mem_we_n, o_mem_oe_n;
  logic              o_mem_lb_n, o_mem_ub_n, o_mem_adv_n, o_mem_cre;

  sram_burst_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .ACCESS_CYC(A),
    .TURN_CYC  (T)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_write (i_cmd_write),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_len   (i_cmd_len),
    .i_wr_data   (i_wr_data),
    .o_wr_ready  (o_wr_ready),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_busy      (o_busy),
    .o_mem_addr  (o_mem_addr),
    .o_mem_dq_out(o_mem_dq_out),
    .o_mem_dq_oe (o_mem_dq_oe),
    .i_mem_dq_in (i_mem_dq_in),
    .o_mem_ce_n  (o_mem_ce_n),
    .o_mem_we_n  (o_mem_we_n),
    .o_mem_oe_n  (o_mem_oe_n),
    .o_mem_lb_n  (o_mem_lb_n),
    .o_mem_ub_n  (o_mem_ub_n),
    .o_mem_adv_n (o_mem_adv_n),
    .o_mem_cre   (o_mem_cre)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  logic [DATA_W-1:0] sram    [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] wr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                wr_rel_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  int                rd_rel_q[$];
  int we_low, we_no_oe, ce_low, ce_high_busy, bus_viol;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_logs();
    wr_rel_q.delete();
    wr_addr_q.delete();
    rd_rel_q.delete();
    we_low = 0;
    we_no_oe = 0;
    ce_low = 0;
    ce_high_busy = 0;
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // SRAM model, write-data feeder and read scoreboard, all sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_wr_ready) begin
      wr_rel_q.push_back(cyc - acc_cyc);
      wr_addr_q.push_back(o_mem_addr);
      if (wr_q.size() != 0) i_wr_data = wr_q.pop_front();
      else check_eq("wr_ready_extra", 1, 0);
    end
    if (o_rd_valid) begin
      rd_rel_q.push_back(cyc - acc_cyc);
      if (exp_q.size() != 0) check_eq("rd_data", o_rd_data, exp_q.pop_front());
      else check_eq("rd_valid_extra", 1, 0);
    end
    if (!o_mem_ce_n && !o_mem_we_n) begin
      sram[o_mem_addr] = o_mem_dq_out;
      we_low++;
      if (!o_mem_dq_oe) we_no_oe++;
    end
    if (!o_mem_oe_n && o_mem_dq_oe) bus_viol++;
    if (!o_mem_oe_n && !o_mem_we_n) bus_viol++;
    if (o_mem_lb_n != o_mem_ce_n || o_mem_ub_n != o_mem_ce_n) bus_viol++;
    if (!o_mem_ce_n) ce_low++;
    if (o_busy && o_mem_ce_n) ce_high_busy++;
    i_mem_dq_in = (!o_mem_oe_n && sram.exists(o_mem_addr)) ? sram[o_mem_addr] : 16'hDEAD;
  end

  // Called mid-cycle; returns just after the accepting edge.
  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [LEN_W-1:0] len);
    int n;
    logic [DATA_W-1:0] d;
    for (int i = 0; i <= int'(len); i++) begin
      if (wr) begin
        d = DATA_W'($urandom);
        ref_mem[ADDR_W'(a + i)] = d;
        wr_q.push_back(d);
      end else begin
        exp_q.push_back(ref_mem.exists(ADDR_W'(a + i)) ? ref_mem[ADDR_W'(a + i)] : 16'hDEAD);
      end
    end
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_len   = len;
    n = 0;
    while (!o_cmd_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_cmd_ready) begin
      check_eq("accept_timeout", 1, 0);
      i_cmd_valid = 1'b0;
    end else begin
      @(posedge i_clk);
      #1;
      acc_cyc = cyc - 1;
      i_cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_clk);
    while ((o_busy || !o_cmd_ready) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) check_eq("idle_timeout", 1, 0);
  endtask

  int n;
  int gap;
  int ce_hb_snap;

  initial begin
    bus_viol    = 0;
    i_rst       = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = '0;
    i_cmd_len   = '0;
    i_wr_data   = '0;
    i_mem_dq_in = '0;
    clear_logs();

    // Reset held 3 cycles with a pending request
    repeat (3) @(negedge i_clk);
    check_eq("rst_outputs",
             {o_mem_ce_n, o_mem_we_n, o_mem_oe_n, o_mem_lb_n, o_mem_ub_n,
              o_mem_dq_oe, o_wr_ready, o_rd_valid, o_busy, o_cmd_ready},
             10'b11111_00000);
    check_eq("rst_rd_data", o_rd_data, 0);
    check_eq("rst_mem_addr", o_mem_addr, 0);
    check_eq("const_adv_cre", {o_mem_adv_n, o_mem_cre}, 2'b00);
    i_rst = 1'b0;
    i_cmd_valid = 1'b0;
    @(negedge i_clk);
    check_eq("ready_after_rst", o_cmd_ready, 1);
    check_eq("no_accept_in_rst", o_busy, 0);

    // Single write then read-back
    clear_logs();
    wr_q.push_back(16'hA5C3);
    ref_mem[23'h000010] = 16'hA5C3;
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = 23'h000010;
    i_cmd_len   = '0;
    @(posedge i_clk);
    #1;
    acc_cyc = cyc - 1;
    i_cmd_valid = 1'b0;
    wait_idle();
    check_eq("sw_wr_ready_cnt", wr_rel_q.size(), 1);
    if (wr_rel_q.size() > 0) check_eq("sw_wr_ready_cyc", wr_rel_q[0], 1);
    check_eq("sw_we_low", we_low, A);
    check_eq("sw_we_no_oe", we_no_oe, 0);
    check_eq("sw_sram", sram.exists(23'h000010) ? sram[23'h000010] : 16'h0, 16'hA5C3);

    clear_logs();
    send_cmd(1'b0, 23'h000010, 4'd0);
    wait_idle();
    check_eq("sr_rd_cnt", rd_rel_q.size(), 1);
    if (rd_rel_q.size() > 0) check_eq("sr_rd_cyc", rd_rel_q[0], A + 2);

    // Burst write across the address wrap
    clear_logs();
    send_cmd(1'b1, 23'h7FFFFE, 4'd3);
    wait_idle();
    check_eq("bw_wr_cnt", wr_rel_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_rel_q.size(); i++) begin
      check_eq("bw_wr_cyc", wr_rel_q[i], 1 + i * (A + 2));
      check_eq("bw_addr", wr_addr_q[i], ADDR_W'(23'h7FFFFE + i));
    end
    check_eq("bw_ce_low", ce_low, 4 * (A + 2));
    check_eq("bw_we_low", we_low, 4 * A);

    // Burst read-back of the same range
    clear_logs();
    send_cmd(1'b0, 23'h7FFFFE, 4'd3);
    wait_idle();
    check_eq("br_rd_cnt", rd_rel_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_rel_q.size(); i++)
      check_eq("br_rd_cyc", rd_rel_q[i], A + 2 + i * (A + 1));
    check_eq("br_ce_low", ce_low, 4 * (A + 1));

    // Back-to-back: read held pending through a write
    clear_logs();
    send_cmd(1'b1, 23'h000020, 4'd0);
    gap = acc_cyc;
    send_cmd(1'b0, 23'h000020, 4'd0);
    gap = acc_cyc - gap;
    ce_hb_snap = ce_high_busy;
    check_eq("b2b_accept_gap", gap, A + 2 + T + 1);
    check_eq("b2b_recover_cyc", ce_hb_snap, T);
    wait_idle();
    check_eq("b2b_rd_cnt", rd_rel_q.size(), 1);

    // Reset during beat 2 of a 4-beat read, on the edge that would end its access
    clear_logs();
    send_cmd(1'b0, 23'h7FFFFE, 4'd3);
    repeat (3) void'(exp_q.pop_back());
    n = 0;
    while ((cyc - acc_cyc) != 2 * (A + 1) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    check_eq("abort_state",
             {o_mem_ce_n, o_mem_we_n, o_mem_oe_n, o_mem_dq_oe, o_busy, o_rd_valid, o_wr_ready,
              o_cmd_ready},
             8'b1110_0000);
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    check_eq("abort_rd_cnt", rd_rel_q.size(), 1);
    check_eq("abort_idle", {o_busy, o_cmd_ready}, 2'b01);

    check_eq("bus_rules", bus_viol, 0);
    check_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised asynchronous-SRAM access controller, the next generation of the board's 4-bit button-driven SRAM controller. It runs single or burst reads and writes over a `cmd_valid`/`cmd_ready` handshake, with a programmable access time and bus turnaround. Data and address widths are generic. The tristate bus is split into `mem_dq_out`/`mem_dq_oe`/`mem_dq_in` so the board top owns the `inout` pad. It sits between the user logic (seven-segment/debug front end or a test pattern engine) and the external cellular RAM, which runs in asynchronous mode.

## Interface
- `DATA_W`, 16, SRAM data width.
- `ADDR_W`, 23, SRAM word address width.
- `LEN_W`, 4, burst length field width; a burst has `cmd_len+1` beats, up to 2^LEN_W.
- `ACCESS_CYC`, 7, clk cycles the strobe (`we_n` or `oe_n`) is held active per beat; must be ≥1.
- `TURN_CYC`, 1, idle cycles with `ce_n` high after a command completes; 0 allowed.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE and not in reset.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  start word address.
- `cmd_len`  in  LEN_W  beats minus one.
- `wr_data`  in  DATA_W  write data; must be valid whenever `wr_ready` is high.
- `wr_ready`  out  1  one-cycle pulse; `wr_data` is sampled at this edge.
- `rd_data`  out  DATA_W  registered read data.
- `rd_valid`  out  1  one-cycle pulse per read beat.
- `busy`  out  1  state ≠ IDLE.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_dq_out`  out  DATA_W  SRAM write data.
- `mem_dq_oe`  out  1  pad output enable.
- `mem_dq_in`  in  DATA_W  SRAM read data.
- `mem_ce_n`, `mem_we_n`, `mem_oe_n`  out  1 each  active-low strobes.
- `mem_lb_n`, `mem_ub_n`  out  1 each  equal to `mem_ce_n`.
- `mem_adv_n`  out  1  constant 0 (async mode).
- `mem_cre`  out  1  constant 0.

## Operation
- **States:** IDLE, SETUP, ACCESS, HOLD (writes only), RECOVER.
- **Accept:** a command is accepted on the edge where `cmd_valid & cmd_ready`. At that edge the controller latches `addr`, `write` and beat counter = `cmd_len`, then enters SETUP.
- **SETUP (1 cycle):**
  - `mem_addr` = current address and `mem_ce_n` = 0.
  - Write: `wr_ready` = 1, `wr_data` is registered into `mem_dq_out`, and `mem_dq_oe` = 1 from the next cycle through HOLD.
  - Read: `mem_oe_n` = 0 and `mem_dq_oe` = 0.
- **ACCESS (`ACCESS_CYC` cycles, counted down):**
  - Write: `mem_we_n` = 0.
  - Read: `mem_oe_n` = 0. `rd_data` ← `mem_dq_in` on the edge ending the last ACCESS cycle.
- **HOLD (write, 1 cycle):** `mem_we_n` = 1 while data and address are still driven.
- **Next beat:** after the last ACCESS cycle (read) or after HOLD (write):
  - If the beat counter ≠ 0: decrement it, address +1, go to SETUP.
  - Otherwise: go to RECOVER, or straight to IDLE when `TURN_CYC` = 0.
- **Address arithmetic:** modulo 2^ADDR_W; all-ones wraps to 0 inside a burst.
- **RECOVER:** all strobes high and `mem_dq_oe` = 0 for `TURN_CYC` cycles, then IDLE.
- **Strobe overlap:** `mem_ce_n` stays low between beats of one burst. `we_n` and `oe_n` are never low together.
- **`mem_dq_oe` rule:** never 1 while `mem_oe_n` is 0.
- **Commands during a command:** `cmd_valid` while busy is ignored (`cmd_ready` = 0). The request must be held; it is accepted on the first IDLE cycle.

## Timing
- **Reset values** (the edge with `rst` = 1): state IDLE; `mem_ce_n`, `mem_we_n`, `mem_oe_n`, `mem_lb_n`, `mem_ub_n` = 1; `mem_dq_oe` = 0; `wr_ready`, `rd_valid`, `busy`, `cmd_ready` = 0; `rd_data` and `mem_addr` = 0. `cmd_ready` = 1 from the first cycle after `rst` falls.
- **Reset mid-operation:** aborts on the next edge. Strobes return high, no `rd_valid` is issued for a partially completed beat, and no further `wr_ready` pulses occur.
- **Cycle numbering:** with acceptance at edge 0, cycle 1 = SETUP.
- **Write beat:** `wr_ready` in cycle 1; `we_n` low in cycles 2..1+A (A = `ACCESS_CYC`); HOLD in cycle 2+A. Beat period A+2.
- **Read beat:** `oe_n` low in cycles 1..1+A; `rd_valid` high in cycle 2+A. Beat period A+1, so `rd_valid` spacing is A+1.
- **Command completion:** the last beat is followed by `TURN_CYC` RECOVER cycles, then IDLE with `cmd_ready` = 1.

## Test plan
- **Reset:** hold `rst` 3 cycles with `cmd_valid` = 1 → every output at its reset value and no acceptance; `cmd_ready` = 1 the cycle after release.
- **Single write then read:** `ACCESS_CYC` = 3, write `0xA5C3` to `0x000010`, then read it back.
  - Write: `we_n` low exactly 3 cycles with `mem_dq_oe` = 1 throughout.
  - Read: `rd_valid` in cycle 5 after acceptance with `rd_data` = `0xA5C3`.
  - Bus: `oe_n` and `mem_dq_oe` are never both active.
- **Burst write with wrap:** `cmd_len` = 3 at `0x7FFFFE` (`ADDR_W` = 23) → `mem_addr` sequence `7FFFFE`, `7FFFFF`, `000000`, `000001`; 4 `wr_ready` pulses spaced 5 cycles; `ce_n` low continuously.
- **Burst read-back** of the same range → 4 `rd_valid` pulses spaced 4 cycles, data matching the bench memory model.
- **Back-to-back commands:** `TURN_CYC` = 2, `cmd_valid` held through a write → second command accepted on the first IDLE cycle, exactly 2 cycles with `ce_n` high in between.
- **Reset during beat 2 of a 4-beat read** → strobes high on the next edge, no further `rd_valid`, `busy` = 0.
